// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

    // Architectural word width that the queue entry layout is built on.
    localparam int XLEN = 32;

    // Default prefetch queue depth. Must be a power of two and at least 2.
    localparam int FETCH_DEPTH = 4;

    // Default address of the first fetch after reset.
    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, occupancy count and asynchronous active-high reset.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful where count says so.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately left out of reset; the pointers and count make it unreadable.
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited memory requests, in-order responses, prefetch queue, redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = XLEN,
    parameter int                    DEPTH      = FETCH_DEPTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] fetch_pc;     // address of the next request
    logic [DATA_WIDTH-1:0] resp_pc;      // address belonging to the next live response
    logic [CW-1:0]         outstanding;  // accepted requests without a response, stale included
    logic [CW-1:0]         stale;        // oldest outstanding requests whose data must be dropped
    logic [CW-1:0]         q_count;
    logic [CW:0]           credit_used;
    logic                  q_full;
    logic                  q_empty;
    logic                  accepted;
    logic                  resp_any;
    logic                  push;
    logic                  pop;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;

    // Credit: queued entries plus in-flight requests may never exceed the queue depth.
    // Only registered state feeds the request, so read data never reaches imem_req_o.
    assign credit_used = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req_o  = !rst_i && !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign accepted    = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding cannot belong to this fetch stream and is ignored.
    assign resp_any   = imem_rvalid_i && (outstanding != '0);
    assign push       = resp_any && !redirect_i && (stale == '0) && !q_full;
    assign push_entry = '{pc: resp_pc, instr: imem_rdata_i};

    assign instr_valid_o = !q_empty && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = head_entry.instr;
    assign instr_pc_o    = head_entry.pc;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // In-flight accounting; a redirect turns everything still in flight into stale.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= '0;
            stale       <= '0;
        end else begin
            outstanding <= outstanding + CW'(accepted) - CW'(resp_any);
            if (redirect_i)
                stale <= outstanding - CW'(resp_any);
            else if (resp_any && (stale != '0))
                stale <= stale - CW'(1);
        end
    end

    // Request and response address tracking; both restart at the word-aligned redirect target.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            resp_pc  <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        end else begin
            if (accepted) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
            if (push)     resp_pc  <= resp_pc + DATA_WIDTH'(4);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a queue-based memory and fetch-stream model.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: requests in flight, in order, with the cycle their data is due.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] m_iq[$];      // PCs delivered to decode but not yet consumed
    logic [31:0] pop_log[$];   // PCs the DUT presented when decode consumed
    logic [31:0] m_fetch_pc = RESET_PC;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9617;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One clock cycle: drive at the falling edge, check outputs, advance the model to the rising edge.
    task automatic step(input bit g, input bit rdy, input bit redir, input logic [31:0] rpc);
        mem_req_t r;
        bit       rv;
        bit       exp_req;
        bit       exp_valid;
        @(negedge clk_i);
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_gnt_i    = g;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_data(mem_q[0].addr) : 32'hDEAD_BEEF;
        exp_req   = !redir && ((m_iq.size() + mem_q.size()) < DEPTH);
        exp_valid = !redir && (m_iq.size() > 0);
        #1;
        check("req", imem_req_o, exp_req);
        if (exp_req) check("addr", imem_addr_o, m_fetch_pc);
        check("valid", instr_valid_o, exp_valid);
        if (exp_valid) begin
            check("head_pc", instr_pc_o, m_iq[0]);
            check("head_instr", instr_o, mem_data(m_iq[0]));
        end
        if (exp_valid && rdy) begin
            pop_log.push_back(instr_pc_o);
            void'(m_iq.pop_front());
        end
        if (rv) begin
            r = mem_q.pop_front();
            if (!r.stale && !redir) m_iq.push_back(r.addr);
        end
        if (redir) begin
            m_iq.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end else if (exp_req && g) begin
            mem_q.push_back('{addr: m_fetch_pc, stale: 1'b0,
                              due: cyc + $urandom_range(lat_max, lat_min)});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        cyc++;
    endtask

    // Reset pulse raised between clock edges, so the outputs must react without a clock.
    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        redirect_i = 1'b0;
        instr_ready_i = 1'b0;
        #1;
        check("rst_async_req", imem_req_o, 1'b0);
        check("rst_async_valid", instr_valid_o, 1'b0);
        @(negedge clk_i);
        check("rst_hold_req", imem_req_o, 1'b0);
        check("rst_hold_valid", instr_valid_o, 1'b0);
        rst_i = 1'b0;
        mem_q.delete();
        m_iq.delete();
        pop_log.delete();
        m_fetch_pc = RESET_PC;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;

        // Reset, then first request at RESET_PC and a steady one-per-cycle stream.
        do_reset();
        lat_min = 1; lat_max = 1;
        step(1, 1, 0, '0);
        check("first_req", imem_req_o, 1'b1);
        check("first_addr", imem_addr_o, RESET_PC);
        for (int i = 0; i < 4; i++) step(1, 1, 0, '0);
        pop_log.delete();
        for (int i = 0; i < 8; i++) step(1, 1, 0, '0);
        check("steady_rate", 32'(pop_log.size()), 32'd8);

        // Decode stalled: queue fills to DEPTH, requests stop, then drains in order.
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, '0);
        check("stall_req_low", imem_req_o, 1'b0);
        check("stall_valid", instr_valid_o, 1'b1);
        check("stall_head", instr_pc_o, 32'h0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, '0);
        check("drain_0", (pop_log.size() > 0) ? pop_log[0] : 32'hX, 32'h0);
        check("drain_1", (pop_log.size() > 1) ? pop_log[1] : 32'hX, 32'h4);
        check("drain_2", (pop_log.size() > 2) ? pop_log[2] : 32'hX, 32'h8);
        check("drain_3", (pop_log.size() > 3) ? pop_log[3] : 32'hX, 32'hC);

        // Redirect with two requests in flight: stale data dropped, stream restarts at 0x100.
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        step(1, 1, 1, 32'h0000_0103);
        step(1, 1, 0, '0);
        check("redir_req", imem_req_o, 1'b1);
        check("redir_addr", imem_addr_o, 32'h0000_0100);
        pop_log.delete();
        budget = 0;
        while (pop_log.size() == 0 && budget < 20) begin
            step(1, 1, 0, '0);
            budget++;
        end
        check("redir_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hX, 32'h0000_0100);

        // Redirect in the same cycle as a response and a ready decode.
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 5; i++) step(1, 1, 0, '0);
        step(1, 1, 1, 32'h0000_0040);
        check("coinc_rvalid_seen", imem_rvalid_i, 1'b1);
        check("coinc_valid_low", instr_valid_o, 1'b0);
        check("coinc_req_low", imem_req_o, 1'b0);
        step(1, 1, 0, '0);
        check("coinc_empty_after", instr_valid_o, 1'b0);

        // Grant withheld: address must hold while the request waits.
        step(0, 1, 1, 32'h0000_0020);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, '0);
            check("hold_addr", imem_addr_o, 32'h0000_0020);
        end
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);

        // Reset in the middle of traffic, then restart at RESET_PC.
        do_reset();
        step(1, 1, 0, '0);
        check("restart_addr", imem_addr_o, RESET_PC);

        // Fetch address wraps around the top of the address space.
        step(1, 1, 1, 32'hFFFF_FFF9);
        step(1, 1, 0, '0);
        check("wrap_f8", imem_addr_o, 32'hFFFF_FFF8);
        step(1, 1, 0, '0);
        check("wrap_fc", imem_addr_o, 32'hFFFF_FFFC);
        step(1, 1, 0, '0);
        check("wrap_0", imem_addr_o, 32'h0000_0000);

        // Random grants, stalls, latencies and redirects against the model.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0,
                 (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction/address width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port redirect_i  input  1  branch/jump taken, restart fetch.
REQ-007 SHALL have port redirect_pc_i  input  DATA_WIDTH  new fetch address.
REQ-008 SHALL have port imem_req_o  output  1  instruction memory request.
REQ-009 SHALL have port imem_addr_o  output  DATA_WIDTH  request word address.
REQ-010 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid_i  input  1  read data valid.
REQ-012 SHALL have port imem_rdata_i  input  DATA_WIDTH  read data.
REQ-013 SHALL have port instr_valid_o  output  1  instruction available to decode.
REQ-014 SHALL have port instr_o  output  DATA_WIDTH  instruction word at queue head.
REQ-015 SHALL have port instr_pc_o  output  DATA_WIDTH  PC of instr_o.
REQ-016 SHALL have port instr_ready_i  input  1  decode consumes head this cycle.

Function
REQ-017 SHALL treat a request as accepted when imem_req_o && imem_gnt_i; fetch PC then advances by 4.
REQ-018 SHALL keep imem_addr_o stable while imem_req_o is high and not granted.
REQ-019 SHALL expect responses in request order, latency >=1 cycle, one rvalid per accepted request.
REQ-020 SHALL assert imem_req_o only when queue_count + outstanding < DEPTH (credit rule; queue never overflows).
REQ-021 SHALL push {pc, rdata} into the queue on each non-stale rvalid; PC is the address of the matching request.
REQ-022 SHALL drive instr_valid_o = queue not empty, instr_o/instr_pc_o = head entry, combinationally from queue state.
REQ-023 SHALL pop the head when instr_valid_o && instr_ready_i; push and pop in the same cycle both take effect.
REQ-024 SHALL, on redirect_i, in that cycle: force imem_req_o and instr_valid_o low, ignore instr_ready_i.
REQ-025 SHALL, on redirect_i, at the clock edge: empty the queue, load fetch PC with {redirect_pc_i[31:2],2'b00}, mark all outstanding requests stale.
REQ-026 SHALL discard (not push) rvalid responses for stale requests, including one arriving in the redirect cycle.
REQ-027 SHALL track outstanding and stale counts of width clog2(DEPTH)+1; counts never exceed DEPTH.
REQ-028 SHALL resume requests the cycle after redirect even while stale responses drain; credit rule counts stale requests as outstanding.
REQ-029 SHALL wrap fetch PC modulo 2^DATA_WIDTH (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-030 SHALL, while rst_i high, hold imem_req_o=0, instr_valid_o=0, queue empty, outstanding=0, stale=0, fetch PC=RESET_PC.
REQ-031 SHALL drop responses arriving after reset deassertion for requests issued before reset (none outstanding by REQ-030 rule; memory must be reset together).
REQ-032 SHALL assert imem_req_o in the first cycle after rst_i deasserts, with imem_addr_o=RESET_PC.

Structure
REQ-033 SHALL place DEPTH default, RESET_PC default and typedef fetch_entry_t {pc, instr} in shared package fetch_pkg.
REQ-034 SHALL implement the queue as sub-module sync_fifo (push, pop, flush, full, empty, count), async active-high reset.
REQ-035 SHALL keep request/credit/stale logic in fetch_unit itself, no latches, no combinational path from imem_rdata_i to imem_req_o.

Verification
REQ-036 Reset then gnt=1, 1-cycle rvalid, ready=1 -> addresses 0,4,8,...; instr_pc_o 0,4,8 in order, one instr/cycle steady state.
REQ-037 ready=0 for 10 cycles, gnt=1 -> exactly 4 instructions queued, imem_req_o low, no overflow; ready=1 drains PCs 0,4,8,12.
REQ-038 Redirect to 32'h0000_0103 with 2 outstanding -> addr 32'h100 next cycle, both stale rvalids discarded, first delivered instr_pc_o=32'h100.
REQ-039 Redirect coinciding with rvalid and ready=1 -> no push, no pop, instr_valid_o low that cycle, queue empty afterward.
REQ-040 gnt held low 5 cycles at addr 32'h20 -> imem_addr_o stays 32'h20; rst_i pulsed mid-stream -> all outputs reset asynchronously, restart at RESET_PC.
